// File: rtl/cc_param_wb_cache_if.sv
// Processor and main-memory signal bundle for cc_param_wb_cache.
// The slave modport is the cache; the master modport is the processor/memory side.
interface cc_param_wb_cache_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
);
  logic              read_c;
  logic              write_c;
  logic              cache_flush;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_mp_to_c;
  logic [DATA_W-1:0] data_c_to_mp;
  logic              cpu_done;
  logic              busy;
  logic              mem_req;
  logic              wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] data_c_to_mem;
  logic [DATA_W-1:0] data_mem_to_c;
  logic              ready;
  logic [CNT_W-1:0]  hit_cnt;
  logic [CNT_W-1:0]  miss_cnt;

  modport slave (
    input  read_c, write_c, cache_flush, address, data_mp_to_c, data_mem_to_c, ready,
    output data_c_to_mp, cpu_done, busy, mem_req, wr, mem_addr, data_c_to_mem,
           hit_cnt, miss_cnt
  );

  modport master (
    output read_c, write_c, cache_flush, address, data_mp_to_c, data_mem_to_c, ready,
    input  data_c_to_mp, cpu_done, busy, mem_req, wr, mem_addr, data_c_to_mem,
           hit_cnt, miss_cnt
  );
endinterface

// File: rtl/cc_param_wb_cache.sv
// Direct-mapped write-back, write-allocate L1 cache controller with a
// sequential whole-cache flush engine and saturating hit/miss counters.
module cc_param_wb_cache #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned INDEX_W = 6,
  parameter int unsigned CNT_W   = 16
) (
  input logic                 clk,
  input logic                 rst,
  cc_param_wb_cache_if.slave  bus
);
  localparam int unsigned LINES = 2 ** INDEX_W;
  localparam int unsigned TAG_W = ADDR_W - INDEX_W;
  localparam logic [INDEX_W-1:0] LastIdx = INDEX_W'(LINES - 1);

  typedef enum logic [2:0] {
    StIdle, StCompare, StWriteback, StRefill, StFlushScan, StFlushWb
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                op_wr_q, op_wr_d;
  logic [INDEX_W-1:0]  fidx_q, fidx_d;
  logic [LINES-1:0]    valid_q, valid_d, dirty_q, dirty_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                done_q, done_d;
  logic                mem_req_q, mem_req_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   wb_data_q, wb_data_d;
  logic [CNT_W-1:0]    hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  logic [TAG_W-1:0]    tag_arr_q  [LINES];
  logic [DATA_W-1:0]   data_arr_q [LINES];

  logic                line_we;
  logic [DATA_W-1:0]   line_data;
  logic [INDEX_W-1:0]  req_idx;
  logic [TAG_W-1:0]    req_tag;
  logic                hit;

  assign req_idx = addr_q[INDEX_W-1:0];
  assign req_tag = addr_q[ADDR_W-1:INDEX_W];
  assign hit     = valid_q[req_idx] && (tag_arr_q[req_idx] == req_tag);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    op_wr_d    = op_wr_q;
    fidx_d     = fidx_q;
    valid_d    = valid_q;
    dirty_d    = dirty_q;
    rdata_d    = rdata_q;
    done_d     = 1'b0;
    mem_req_d  = mem_req_q;
    wr_d       = wr_q;
    mem_addr_d = mem_addr_q;
    wb_data_d  = wb_data_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    line_we    = 1'b0;
    line_data  = wdata_q;

    case (state_q)
      StIdle: begin
        mem_req_d = 1'b0;
        if (bus.cache_flush) begin
          fidx_d  = '0;
          state_d = StFlushScan;
        end else if (bus.write_c || bus.read_c) begin
          addr_d  = bus.address;
          wdata_d = bus.data_mp_to_c;
          op_wr_d = bus.write_c;
          state_d = StCompare;
        end
      end
      StCompare: begin
        if (hit) begin
          if (hit_cnt_q != {CNT_W{1'b1}}) hit_cnt_d = hit_cnt_q + 1'b1;
          if (op_wr_q) begin
            line_we          = 1'b1;
            dirty_d[req_idx] = 1'b1;
          end else begin
            rdata_d = data_arr_q[req_idx];
          end
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          if (miss_cnt_q != {CNT_W{1'b1}}) miss_cnt_d = miss_cnt_q + 1'b1;
          if (valid_q[req_idx] && dirty_q[req_idx]) begin
            mem_req_d  = 1'b1;
            wr_d       = 1'b1;
            mem_addr_d = {tag_arr_q[req_idx], req_idx};
            wb_data_d  = data_arr_q[req_idx];
            state_d    = StWriteback;
          end else if (op_wr_q) begin
            line_we          = 1'b1;
            valid_d[req_idx] = 1'b1;
            dirty_d[req_idx] = 1'b1;
            done_d           = 1'b1;
            state_d          = StIdle;
          end else begin
            state_d = StRefill;
          end
        end
      end
      StWriteback: begin
        if (bus.ready) begin
          mem_req_d        = 1'b0;
          dirty_d[req_idx] = 1'b0;
          if (op_wr_q) begin
            line_we          = 1'b1;
            valid_d[req_idx] = 1'b1;
            dirty_d[req_idx] = 1'b1;
            done_d           = 1'b1;
            state_d          = StIdle;
          end else begin
            state_d = StRefill;
          end
        end
      end
      StRefill: begin
        // Request is raised one cycle after entry so a preceding write-back leaves a gap.
        if (!mem_req_q) begin
          mem_req_d  = 1'b1;
          wr_d       = 1'b0;
          mem_addr_d = addr_q;
        end else if (bus.ready) begin
          mem_req_d        = 1'b0;
          line_we          = 1'b1;
          line_data        = bus.data_mem_to_c;
          valid_d[req_idx] = 1'b1;
          dirty_d[req_idx] = 1'b0;
          rdata_d          = bus.data_mem_to_c;
          done_d           = 1'b1;
          state_d          = StIdle;
        end
      end
      StFlushScan: begin
        if (valid_q[fidx_q] && dirty_q[fidx_q]) begin
          mem_req_d  = 1'b1;
          wr_d       = 1'b1;
          mem_addr_d = {tag_arr_q[fidx_q], fidx_q};
          wb_data_d  = data_arr_q[fidx_q];
          state_d    = StFlushWb;
        end else if (fidx_q == LastIdx) begin
          valid_d = '0;
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          fidx_d = fidx_q + 1'b1;
        end
      end
      StFlushWb: begin
        if (bus.ready) begin
          mem_req_d       = 1'b0;
          dirty_d[fidx_q] = 1'b0;
          if (fidx_q == LastIdx) begin
            valid_d = '0;
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            fidx_d  = fidx_q + 1'b1;
            state_d = StFlushScan;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      wdata_q    <= '0;
      op_wr_q    <= 1'b0;
      fidx_q     <= '0;
      valid_q    <= '0;
      dirty_q    <= '0;
      rdata_q    <= '0;
      done_q     <= 1'b0;
      mem_req_q  <= 1'b0;
      wr_q       <= 1'b0;
      mem_addr_q <= '0;
      wb_data_q  <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      op_wr_q    <= op_wr_d;
      fidx_q     <= fidx_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      rdata_q    <= rdata_d;
      done_q     <= done_d;
      mem_req_q  <= mem_req_d;
      wr_q       <= wr_d;
      mem_addr_q <= mem_addr_d;
      wb_data_q  <= wb_data_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Tag/data storage carries no reset; contents are qualified by valid_q.
  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_arr_q[req_idx]  <= req_tag;
      data_arr_q[req_idx] <= line_data;
    end
  end

  assign bus.data_c_to_mp  = rdata_q;
  assign bus.cpu_done      = done_q;
  assign bus.busy          = (state_q != StIdle);
  assign bus.mem_req       = mem_req_q;
  assign bus.wr            = wr_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.data_c_to_mem = wb_data_q;
  assign bus.hit_cnt       = hit_cnt_q;
  assign bus.miss_cnt      = miss_cnt_q;
endmodule

// File: doc/cc_param_wb_cache.md
Name: cc_param_wb_cache

Overview:
Parametrised direct-mapped, write-back, write-allocate L1 cache controller. It sits between the microprocessor port (read_c/write_c/cache_flush) and the main-memory port (mem_req/wr/ready). It generalises the fixed 16-bit-address, 32-bit-data controller in address width, data width and line count. It adds a sequential whole-cache flush engine and saturating hit/miss counters.

Parameters:
ADDR_W, 16, byte-less word address width.
DATA_W, 32, data word width.
INDEX_W, 6, index bits; LINES = 2**INDEX_W lines of one word each; tag width = ADDR_W-INDEX_W (must be >=1).
CNT_W, 16, width of hit/miss counters.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
read_c  in  1  processor read request
write_c  in  1  processor write request
cache_flush  in  1  processor flush request
address  in  ADDR_W  request address; index = address[INDEX_W-1:0], tag = upper bits
data_mp_to_c  in  DATA_W  processor write data
data_c_to_mp  out  DATA_W  read data to processor, valid with cpu_done
cpu_done  out  1  one-cycle completion pulse
busy  out  1  high whenever FSM not IDLE
mem_req  out  1  memory transaction request, held until ready
wr  out  1  1 = memory write, 0 = memory read; valid while mem_req
mem_addr  out  ADDR_W  memory address, valid while mem_req
data_c_to_mem  out  DATA_W  write-back data, valid while mem_req&wr
data_mem_to_c  in  DATA_W  refill data, sampled when ready
ready  in  1  memory completion, one cycle; ignored when mem_req=0
hit_cnt  out  CNT_W  read/write hits, saturating
miss_cnt  out  CNT_W  read/write misses, saturating

Behaviour:
- Reset (rst=0, async): FSM to IDLE; all valid/dirty bits cleared; all outputs and counters 0. In-flight memory transaction is abandoned. Tag/data arrays need no reset.
- States: IDLE, COMPARE, WRITEBACK, REFILL, FLUSH_SCAN, FLUSH_WB. All outputs are registered.
- IDLE: samples requests each cycle. Priority is cache_flush > write_c > read_c. Accepting latches address, data and op, then goes to COMPARE (flush goes to FLUSH_SCAN with idx=0). Requests while busy=1 are ignored, not queued.
- COMPARE, hit (valid & tag match):
  - Read: data_c_to_mp = line data.
  - Write: line data = write data, dirty=1.
  - hit_cnt++; return to IDLE with cpu_done=1.
  - Hit latency: request cycle N, cpu_done in cycle N+2 (first IDLE cycle). A new request may be accepted in that cycle.
- COMPARE, miss: miss_cnt++.
  - If victim valid&dirty, go to WRITEBACK.
  - Otherwise a read goes to REFILL, and a write installs immediately (tag, data, valid=1, dirty=1) and returns to IDLE with cpu_done.
- WRITEBACK: mem_req=1, wr=1, mem_addr={victim tag, index}, data_c_to_mem = victim data, all held stable until ready.
  - On ready: mem_req drops next cycle and the line is marked clean.
  - Then a read goes to REFILL; a write installs as above and completes.
- REFILL: mem_req=1, wr=0, mem_addr = latched address, held until ready.
  - On ready: install data_mem_to_c with valid=1, dirty=0; data_c_to_mp = data_mem_to_c; return to IDLE with cpu_done.
- Flush:
  - FLUSH_SCAN examines line idx. If valid&dirty, go to FLUSH_WB (write-back as in WRITEBACK, then clear dirty). Otherwise advance idx.
  - After idx = LINES-1 is done: all valid bits cleared, IDLE, cpu_done=1. Counters are unchanged by flush.
  - A clean-cache flush takes LINES scan cycles.
  - Write-backs are issued in ascending index order.
- Counters saturate at all-ones and never wrap.
- mem_req and wr never change while waiting for ready. Every completed memory transaction produces mem_req=0 for at least one cycle before the next one.

Test Plan:
1. Reset, read 0x0040, ready 3 cycles after mem_req -> one mem read at mem_addr 0x0040, wr=0. cpu_done with data_c_to_mp=0xDEADBEEF (memory value). miss_cnt=1. Re-read 0x0040 -> cpu_done 2 cycles after request, no mem_req, hit_cnt=1.
2. Write 0x0041 data 0x12345678 to an empty cache -> no mem_req, cpu_done, miss_cnt increments. Read 0x0041 -> hit returning 0x12345678.
3. After scenario 2, read 0x0441 (same index 1, tag 17) -> mem write at 0x0041 with data 0x12345678, then mem read at 0x0441. The refill value is returned, and the line is now clean.
4. Dirty lines at index 1 and 5, cache_flush -> exactly two mem writes (index 1 then 5), cpu_done after the scan. A subsequent read 0x0041 misses and refills.
5. read_c and write_c asserted together on 0x0002 -> write performed. A read_c pulse while busy=1 is ignored (no extra cpu_done, counters unchanged). Force miss_cnt to all-ones -> stays all-ones.
6. rst=0 while waiting in REFILL -> mem_req, busy and counters go to 0 immediately. After release, reading the same address misses again.
